// File: rtl/vga_pattern_engine_pkg.sv
// Shared types and constants for the VGA pattern engine: opcodes, display modes,
// colour/config records and FSM state encodings.
package vga_pattern_engine_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_SOLID   = 2'd1,
    MODE_GRID    = 2'd2,
    MODE_CHECKER = 2'd3
  } mode_t;

  localparam logic [3:0] OP_NOP       = 4'd0;
  localparam logic [3:0] OP_SET_BG    = 4'd1;
  localparam logic [3:0] OP_SET_HLINE = 4'd2;
  localparam logic [3:0] OP_SET_VLINE = 4'd3;
  localparam logic [3:0] OP_SET_MODE  = 4'd4;

  // Colours are kept at full byte precision; only the top CW bits reach the pins.
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb8_t;

  typedef struct packed {
    rgb8_t bg;
    rgb8_t hline;
    rgb8_t vline;
    mode_t mode;
  } disp_cfg_t;

  localparam rgb8_t BG_DEFAULT    = rgb8_t'({8'h30, 8'h00, 8'h80});
  localparam rgb8_t HLINE_DEFAULT = rgb8_t'({8'h00, 8'hF0, 8'h00});
  localparam rgb8_t VLINE_DEFAULT = rgb8_t'({8'hF0, 8'h00, 8'hF0});

  localparam disp_cfg_t CFG_DEFAULT = disp_cfg_t'({BG_DEFAULT, HLINE_DEFAULT,
                                                   VLINE_DEFAULT, MODE_GRID});

  typedef enum logic [1:0] {PS_OPC, PS_P0, PS_P1, PS_P2} parse_state_t;
  typedef enum logic [1:0] {RS_IDLE, RS_STROBE, RS_LATCH, RS_RECOV} rd_state_t;
  typedef enum logic [1:0] {SEL_BLACK, SEL_BG, SEL_HLINE, SEL_VLINE} pix_sel_t;

endpackage

// File: rtl/vga_pattern_engine_cmd_fifo_reader.sv
// Command FIFO reader: paces active-low read strobes against a registered
// active-low empty flag and hands each byte on with a one-cycle valid.
module vga_pattern_engine_cmd_fifo_reader
  import vga_pattern_engine_pkg::*;
#(
  parameter int RD_LOW   = 2,
  parameter int RD_RECOV = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_nef,
  input  logic [7:0] i_data,
  output logic       o_rd_n,
  output logic [7:0] o_byte,
  output logic       o_byte_vld
);

  rd_state_t  r_state, w_state_nxt;
  logic [7:0] r_cnt, w_cnt_nxt;
  logic       r_rd_n, w_rd_n_nxt;
  logic       r_vld, w_vld_nxt;
  logic       w_capture;
  logic [7:0] r_byte;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RS_IDLE;
      r_cnt   <= 8'd0;
      r_rd_n  <= 1'b1;
      r_vld   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rd_n  <= w_rd_n_nxt;
      r_vld   <= w_vld_nxt;
    end
  end

  // Data is sampled on the same edge that releases the strobe, while still valid.
  always_ff @(posedge clk) begin
    if (w_capture) r_byte <= i_data;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = 8'd0;
    w_rd_n_nxt  = 1'b1;
    w_vld_nxt   = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      RS_IDLE: begin
        if (i_nef) begin
          w_state_nxt = RS_STROBE;
          w_rd_n_nxt  = 1'b0;
        end
      end
      RS_STROBE: begin
        if (r_cnt == 8'(RD_LOW - 1)) begin
          w_state_nxt = RS_LATCH;
          w_capture   = 1'b1;
          w_vld_nxt   = 1'b1;
        end else begin
          w_rd_n_nxt = 1'b0;
          w_cnt_nxt  = r_cnt + 8'd1;
        end
      end
      RS_LATCH: w_state_nxt = RS_RECOV;
      RS_RECOV: begin
        if (r_cnt == 8'(RD_RECOV - 1)) w_state_nxt = RS_IDLE;
        else                           w_cnt_nxt   = r_cnt + 8'd1;
      end
      default: w_state_nxt = RS_IDLE;
    endcase
  end

  assign o_rd_n     = r_rd_n;
  assign o_byte     = r_byte;
  assign o_byte_vld = r_vld;

endmodule

// File: rtl/vga_pattern_engine.sv
// Pixel-colour stage: parses FIFO commands into a shadow config, commits it at
// the frame origin, and renders off/solid/grid/checker patterns with one-cycle latency.
module vga_pattern_engine
  import vga_pattern_engine_pkg::*;
#(
  parameter int CW        = 4,
  parameter int CELL_W_LG = 4,
  parameter int CELL_H_LG = 4,
  parameter int RD_LOW    = 2,
  parameter int RD_RECOV  = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [15:0]   hcount,
  input  logic [15:0]   vcount,
  input  logic          vis,
  input  logic          nef,
  input  logic [7:0]    disp_cmd_in,
  output logic          disp_cmd_rd,
  output logic [CW-1:0] red,
  output logic [CW-1:0] green,
  output logic [CW-1:0] blue
);

  logic [7:0]   w_byte;
  logic         w_byte_vld;
  logic [3:0]   w_op;
  logic         w_frame_start;
  parse_state_t r_pstate, w_pstate_nxt;
  logic [1:0]   r_tgt;
  logic [7:0]   r_pend_r, r_pend_g;
  disp_cfg_t    r_shadow, r_active;
  pix_sel_t     w_sel;
  rgb8_t        w_col;

  vga_pattern_engine_cmd_fifo_reader #(
    .RD_LOW   (RD_LOW),
    .RD_RECOV (RD_RECOV)
  ) u_reader (
    .clk        (clk),
    .rst        (rst),
    .i_nef      (nef),
    .i_data     (disp_cmd_in),
    .o_rd_n     (disp_cmd_rd),
    .o_byte     (w_byte),
    .o_byte_vld (w_byte_vld)
  );

  assign w_op          = w_byte[7:4];
  assign w_frame_start = (hcount == 16'd0) && (vcount == 16'd0);

  always_ff @(posedge clk) begin
    if (rst) r_pstate <= PS_OPC;
    else     r_pstate <= w_pstate_nxt;
  end

  always_comb begin
    w_pstate_nxt = r_pstate;
    if (w_byte_vld) begin
      case (r_pstate)
        PS_OPC: begin
          if (w_op == OP_SET_BG || w_op == OP_SET_HLINE || w_op == OP_SET_VLINE)
            w_pstate_nxt = PS_P0;
        end
        PS_P0:   w_pstate_nxt = PS_P1;
        PS_P1:   w_pstate_nxt = PS_P2;
        default: w_pstate_nxt = PS_OPC;
      endcase
    end
  end

  // Commit reads the pre-write shadow, so a colour landing on the origin waits a frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shadow <= CFG_DEFAULT;
      r_active <= CFG_DEFAULT;
      r_tgt    <= 2'd0;
      r_pend_r <= 8'd0;
      r_pend_g <= 8'd0;
    end else begin
      if (w_frame_start) r_active <= r_shadow;
      if (w_byte_vld) begin
        case (r_pstate)
          PS_OPC: begin
            r_tgt <= w_op[1:0];
            if (w_op == OP_SET_MODE) r_shadow.mode <= mode_t'(w_byte[1:0]);
          end
          PS_P0: r_pend_r <= w_byte;
          PS_P1: r_pend_g <= w_byte;
          default: begin
            case (r_tgt)
              2'd1:    r_shadow.bg    <= rgb8_t'({r_pend_r, r_pend_g, w_byte});
              2'd2:    r_shadow.hline <= rgb8_t'({r_pend_r, r_pend_g, w_byte});
              default: r_shadow.vline <= rgb8_t'({r_pend_r, r_pend_g, w_byte});
            endcase
          end
        endcase
      end
    end
  end

  always_comb begin
    w_sel = SEL_BLACK;
    if (vis) begin
      case (r_active.mode)
        MODE_SOLID: w_sel = SEL_BG;
        MODE_GRID: begin
          if (vcount[CELL_H_LG-1:0] == '0)      w_sel = SEL_HLINE;
          else if (hcount[CELL_W_LG-1:0] == '0) w_sel = SEL_VLINE;
          else                                  w_sel = SEL_BG;
        end
        MODE_CHECKER: begin
          if (hcount[CELL_W_LG] ^ vcount[CELL_H_LG]) w_sel = SEL_VLINE;
          else                                       w_sel = SEL_BG;
        end
        default: w_sel = SEL_BLACK;
      endcase
    end
  end

  always_comb begin
    w_col = rgb8_t'(24'd0);
    case (w_sel)
      SEL_BG:    w_col = r_active.bg;
      SEL_HLINE: w_col = r_active.hline;
      SEL_VLINE: w_col = r_active.vline;
      default:   w_col = rgb8_t'(24'd0);
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      red   <= '0;
      green <= '0;
      blue  <= '0;
    end else begin
      red   <= w_col.r[7 -: CW];
      green <= w_col.g[7 -: CW];
      blue  <= w_col.b[7 -: CW];
    end
  end

endmodule

// File: tb/tb_vga_pattern_engine.sv
// Scoreboard bench for vga_pattern_engine: behavioural command FIFO, pixel
// vectors with queued expectations, and a second instance with other cell sizes.
module tb_vga_pattern_engine;

  localparam int CW       = 4;
  localparam int RD_LOW   = 2;
  localparam int RD_RECOV = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [15:0]   hcount, vcount;
  logic          vis, nef;
  logic [7:0]    disp_cmd_in;
  logic          disp_cmd_rd;
  logic [CW-1:0] red, green, blue;

  logic          nef2;
  logic [7:0]    cmd2;
  logic          rd2;
  logic [CW-1:0] red2, green2, blue2;

  always #5 clk = ~clk;

  vga_pattern_engine #(
    .CW(CW), .CELL_W_LG(4), .CELL_H_LG(4), .RD_LOW(RD_LOW), .RD_RECOV(RD_RECOV)
  ) dut (
    .clk(clk), .rst(rst), .hcount(hcount), .vcount(vcount), .vis(vis),
    .nef(nef), .disp_cmd_in(disp_cmd_in), .disp_cmd_rd(disp_cmd_rd),
    .red(red), .green(green), .blue(blue)
  );

  vga_pattern_engine #(
    .CW(CW), .CELL_W_LG(3), .CELL_H_LG(5), .RD_LOW(RD_LOW), .RD_RECOV(RD_RECOV)
  ) dut2 (
    .clk(clk), .rst(rst), .hcount(hcount), .vcount(vcount), .vis(vis),
    .nef(nef2), .disp_cmd_in(cmd2), .disp_cmd_rd(rd2),
    .red(red2), .green(green2), .blue(blue2)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [7:0]  fifo_q[$];
  logic [11:0] exp_q[$];
  int          run_q[$];
  int          run_len = 0;
  bit          nef_en = 1'b1;

  // FIFO model: flag and data change on the falling edge; a byte is consumed when the strobe rises.
  always @(negedge clk) begin
    nef         = nef_en && (fifo_q.size() > 0);
    disp_cmd_in = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
    if (disp_cmd_rd === 1'b0) run_len++;
    else if (run_len > 0) begin
      run_q.push_back(run_len);
      run_len = 0;
    end
  end

  always @(posedge disp_cmd_rd) begin
    if (fifo_q.size() > 0) fifo_q.delete(0);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached (got no finish, expected finish)");
    $fatal(1, "watchdog");
  end

  task automatic drive_px(input logic [15:0] h, input logic [15:0] v,
                          input logic vi, input logic [11:0] e);
    @(negedge clk);
    hcount = h;
    vcount = v;
    vis    = vi;
    exp_q.push_back(e);
  endtask

  task automatic test_reset;
    logic [11:0] e;
    bit          low_seen;
    rst = 1'b1; vis = 1'b1; hcount = 16'd5; vcount = 16'd5;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({red, green, blue} !== 12'h000) begin
      n_err++;
      $display("FAIL reset_rgb: got %h expected 000", {red, green, blue});
    end
    n_vec++;
    if (disp_cmd_rd !== 1'b1) begin
      n_err++;
      $display("FAIL reset_rd: got %b expected 1", disp_cmd_rd);
    end
    @(negedge clk);
    rst = 1'b0;
    drive_px(16'd5, 16'd5, 1'b1, 12'h308);
    @(posedge clk); #1;
    e = exp_q.pop_front();
    n_vec++;
    if ({red, green, blue} !== e) begin
      n_err++;
      $display("FAIL reset_bg: got %h expected %h", {red, green, blue}, e);
    end
    low_seen = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (disp_cmd_rd !== 1'b1) low_seen = 1'b1;
    end
    n_vec++;
    if (low_seen) begin
      n_err++;
      $display("FAIL reset_rd_idle: rd went low with empty FIFO, expected stay 1");
    end
  endtask

  task automatic test_grid;
    logic [15:0] hv[6] = '{16'd32, 16'd32, 16'd33, 16'd33, 16'd0, 16'd5};
    logic [15:0] vv[6] = '{16'd16, 16'd17, 16'd17, 16'd17, 16'd16, 16'd5};
    logic        vi[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [11:0] ev[6] = '{12'h0F0, 12'hF0F, 12'h308, 12'h000, 12'h0F0, 12'h308};
    logic [11:0] e;
    for (int i = 0; i < 6; i++) begin
      drive_px(hv[i], vv[i], vi[i], ev[i]);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_vec++;
      if ({red, green, blue} !== e) begin
        n_err++;
        $display("FAIL grid[%0d] h=%0d v=%0d: got %h expected %h", i, hv[i], vv[i], {red, green, blue}, e);
      end
    end
  endtask

  task automatic test_fifo_commit;
    logic [11:0] e;
    logic [15:0] hv[3] = '{16'd0, 16'd5, 16'd32};
    logic [15:0] vv[3] = '{16'd0, 16'd5, 16'd16};
    logic [11:0] ev[3] = '{12'h0F0, 12'hFF0, 12'h0F0};
    run_q.delete();
    fifo_q.push_back(8'h10); fifo_q.push_back(8'hF0);
    fifo_q.push_back(8'hF0); fifo_q.push_back(8'h00);
    for (int i = 0; i < 40; i++) begin
      drive_px(16'd5, 16'd5, 1'b1, 12'h308);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_vec++;
      if ({red, green, blue} !== e) begin
        n_err++;
        $display("FAIL midframe[%0d]: got %h expected %h", i, {red, green, blue}, e);
      end
    end
    n_vec++;
    if (fifo_q.size() != 0) begin
      n_err++;
      $display("FAIL fifo_drain: %0d bytes left, expected 0", fifo_q.size());
    end
    for (int i = 0; i < 3; i++) begin
      drive_px(hv[i], vv[i], 1'b1, ev[i]);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_vec++;
      if ({red, green, blue} !== e) begin
        n_err++;
        $display("FAIL commit[%0d]: got %h expected %h", i, {red, green, blue}, e);
      end
    end
    n_vec++;
    if (run_q.size() != 4) begin
      n_err++;
      $display("FAIL strobe_count: got %0d expected 4", run_q.size());
    end
    foreach (run_q[i]) begin
      n_vec++;
      if (run_q[i] != RD_LOW) begin
        n_err++;
        $display("FAIL strobe_len[%0d]: got %0d expected %0d", i, run_q[i], RD_LOW);
      end
    end
  endtask

  task automatic test_nef_idle;
    int lows = 0;
    bit found = 1'b0;
    @(posedge clk); #2;
    nef_en = 1'b0;
    fifo_q.push_back(8'h00);
    repeat (1000) begin
      @(negedge clk);
      if (disp_cmd_rd !== 1'b1) lows++;
    end
    n_vec++;
    if (lows != 0) begin
      n_err++;
      $display("FAIL nef_low_idle: rd low %0d cycles, expected 0", lows);
    end
    @(posedge clk); #2;
    nef_en = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      if (disp_cmd_rd === 1'b0) found = 1'b1;
    end
    n_vec++;
    if (!found) begin
      n_err++;
      $display("FAIL nef_strobe: no strobe within 2 cycles, expected rd=0");
    end
    for (int i = 0; i < 20 && fifo_q.size() != 0; i++) @(posedge clk);
    repeat (6) @(posedge clk);
  endtask

  task automatic test_reset_mid_parse;
    logic [11:0] e;
    bit          saw_low = 1'b0;
    logic [15:0] hv[7] = '{16'd0, 16'd16, 16'd5, 16'd16, 16'd0, 16'd16, 16'd33};
    logic [15:0] vv[7] = '{16'd0, 16'd0, 16'd5, 16'd16, 16'd16, 16'd0, 16'd17};
    logic        vi[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [11:0] ev[7] = '{12'h0F0, 12'hF0F, 12'h308, 12'h308, 12'hF0F, 12'h000, 12'hF0F};
    fifo_q.push_back(8'h20); fifo_q.push_back(8'h11);
    for (int i = 0; i < 40 && fifo_q.size() != 0; i++) @(posedge clk);
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    drive_px(16'd32, 16'd16, 1'b1, 12'h0F0);
    @(posedge clk); #1;
    e = exp_q.pop_front();
    n_vec++;
    if ({red, green, blue} !== e) begin
      n_err++;
      $display("FAIL rst_hline: got %h expected %h", {red, green, blue}, e);
    end
    fifo_q.push_back(8'h41);
    for (int i = 0; i < 20 && !saw_low; i++) begin
      @(posedge clk); #1;
      if (disp_cmd_rd === 1'b0) saw_low = 1'b1;
    end
    n_vec++;
    if (!saw_low) begin
      n_err++;
      $display("FAIL mid_strobe_wait: rd never went low, expected strobe");
    end
    rst = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if (disp_cmd_rd !== 1'b1) begin
      n_err++;
      $display("FAIL rst_mid_strobe_rd: got %b expected 1", disp_cmd_rd);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    drive_px(16'd0, 16'd0, 1'b1, 12'h0F0);
    @(posedge clk); #1;
    e = exp_q.pop_front();
    n_vec++;
    if ({red, green, blue} !== e) begin
      n_err++;
      $display("FAIL lost_byte_commit: got %h expected %h", {red, green, blue}, e);
    end
    drive_px(16'd32, 16'd16, 1'b1, 12'h0F0);
    @(posedge clk); #1;
    e = exp_q.pop_front();
    n_vec++;
    if ({red, green, blue} !== e) begin
      n_err++;
      $display("FAIL lost_byte_mode: got %h expected %h", {red, green, blue}, e);
    end
    fifo_q.push_back(8'h7F); fifo_q.push_back(8'h43);
    for (int i = 0; i < 30; i++) begin
      drive_px(16'd5, 16'd5, 1'b1, 12'h308);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_vec++;
      if ({red, green, blue} !== e) begin
        n_err++;
        $display("FAIL pre_checker[%0d]: got %h expected %h", i, {red, green, blue}, e);
      end
    end
    for (int i = 0; i < 7; i++) begin
      drive_px(hv[i], vv[i], vi[i], ev[i]);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_vec++;
      if ({red, green, blue} !== e) begin
        n_err++;
        $display("FAIL checker[%0d] h=%0d v=%0d: got %h expected %h", i, hv[i], vv[i], {red, green, blue}, e);
      end
    end
  endtask

  task automatic test_cell_params;
    logic [11:0] e;
    logic [15:0] hv[4] = '{16'd8, 16'd8, 16'd0, 16'd7};
    logic [15:0] vv[4] = '{16'd0, 16'd32, 16'd32, 16'd0};
    logic [11:0] ev[4] = '{12'hF0F, 12'h308, 12'hF0F, 12'h308};
    repeat (10) @(posedge clk);
    @(negedge clk);
    hcount = 16'd0; vcount = 16'd0; vis = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_px(hv[i], vv[i], 1'b1, ev[i]);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_vec++;
      if ({red2, green2, blue2} !== e) begin
        n_err++;
        $display("FAIL cell_checker[%0d] h=%0d v=%0d: got %h expected %h", i, hv[i], vv[i], {red2, green2, blue2}, e);
      end
    end
  endtask

  initial begin
    rst = 1'b1; hcount = 16'd5; vcount = 16'd5; vis = 1'b0;
    nef = 1'b0; disp_cmd_in = 8'h00;
    nef2 = 1'b1; cmd2 = 8'h43;
    test_reset();
    test_grid();
    test_fifo_commit();
    test_nef_idle();
    test_reset_mid_parse();
    test_cell_params();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
